// File: rtl/sdram_slot_arbiter.sv
// Per-slot SDRAM access arbiter between the CPU/video port and a DMA port.
// Define ARB_STARVE_GUARD_EN to let a starved DMA port occasionally pre-empt the CPU.
module sdram_slot_arbiter #(
   parameter int unsigned SLOT_LEN     = 14,
   parameter int unsigned DATA_PHASE   = 9,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clkref,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [24:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   input  logic        cpu_aux,
   output logic [15:0] cpu_dout,
   output logic        cpu_valid,
   output logic        cpu_wait,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [24:0] dma_addr,
   input  logic [7:0]  dma_din,
   input  logic        dma_aux,
   output logic        dma_ack,
   output logic [15:0] dma_dout,
   output logic        dma_valid,
   output logic [24:0] sd_addr,
   output logic        sd_we,
   output logic [7:0]  sd_din,
   output logic        sd_aux,
   input  logic [15:0] sd_dout
);

   localparam int unsigned   PW        = $clog2(SLOT_LEN);
   localparam logic [PW-1:0] PhaseLast = PW'(SLOT_LEN - 1);
   localparam logic [PW-1:0] PhaseData = PW'(DATA_PHASE);
   localparam logic [3:0]    StarveLim = 4'(STARVE_LIMIT);

   localparam logic [1:0] OwnIdle = 2'd0;
   localparam logic [1:0] OwnCpu  = 2'd1;
   localparam logic [1:0] OwnDma  = 2'd2;

   logic [PW-1:0] phase;
   logic          clkref_d;
   logic          locked;
   logic          clkref_rise;
   logic          decide;
   logic          force_dma;
   logic [1:0]    owner;
   logic [1:0]    owner_nxt;

   assign clkref_rise = clkref & ~clkref_d;
   assign decide      = locked & (phase == PhaseLast);

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;
   logic       cpu_wait_q;

   assign force_dma = dma_req & (starve_cnt >= StarveLim);
   assign cpu_wait  = cpu_wait_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         cpu_wait_q <= 1'b0;
      end else if (decide) begin
         cpu_wait_q <= force_dma;
         if (!dma_req || (owner_nxt == OwnDma)) begin
            starve_cnt <= '0;
         end else if (starve_cnt != 4'hf) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end
`else
   logic unused_starve_lim;
   assign unused_starve_lim = ^StarveLim;
   assign force_dma         = 1'b0;
   assign cpu_wait          = 1'b0;
`endif

   always_comb begin
      owner_nxt = OwnIdle;
      if (force_dma) begin
         owner_nxt = OwnDma;
      end else if (cpu_req) begin
         owner_nxt = OwnCpu;
      end else if (dma_req) begin
         owner_nxt = OwnDma;
      end
   end

   // clkref_d resets high so a clkref already high at release is not taken as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clkref_d  <= 1'b1;
         phase     <= PhaseLast;
         locked    <= 1'b0;
         owner     <= OwnIdle;
         sd_addr   <= '0;
         sd_we     <= 1'b0;
         sd_din    <= '0;
         sd_aux    <= 1'b0;
         cpu_dout  <= '0;
         dma_dout  <= '0;
         cpu_valid <= 1'b0;
         dma_valid <= 1'b0;
         dma_ack   <= 1'b0;
      end else begin
         clkref_d  <= clkref;
         cpu_valid <= 1'b0;
         dma_valid <= 1'b0;
         dma_ack   <= 1'b0;

         if (clkref_rise) begin
            phase  <= '0;
            locked <= 1'b1;
         end else if (phase != PhaseLast) begin
            phase <= phase + PW'(1);
         end

         if (decide) begin
            owner <= owner_nxt;
            case (owner_nxt)
               OwnCpu: begin
                  sd_addr <= cpu_addr;
                  sd_we   <= cpu_we;
                  sd_din  <= cpu_din;
                  sd_aux  <= cpu_aux;
               end
               OwnDma: begin
                  sd_addr <= dma_addr;
                  sd_we   <= dma_we;
                  sd_din  <= dma_din;
                  sd_aux  <= dma_aux;
                  dma_ack <= 1'b1;
               end
               // Idle slot: address held, write dropped -> harmless dummy read.
               default: sd_we <= 1'b0;
            endcase
         end

         if ((phase == PhaseData) && !sd_we) begin
            if (owner == OwnCpu) begin
               cpu_dout  <= sd_dout;
               cpu_valid <= 1'b1;
            end else if (owner == OwnDma) begin
               dma_dout  <= sd_dout;
               dma_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: slot-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sdram_slot_arbiter;

   localparam int SlotLen   = 14;
   localparam int DataPhase = 9;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit Guard = 1'b1;
`else
   localparam bit Guard = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clkref = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_aux = 1'b0;
   logic [24:0] cpu_addr = '0;
   logic [7:0]  cpu_din = '0;
   logic        dma_req = 1'b0, dma_we = 1'b0, dma_aux = 1'b0;
   logic [24:0] dma_addr = '0;
   logic [7:0]  dma_din = '0;
   logic [15:0] sd_dout = '0;

   logic [15:0] cpu_dout, dma_dout;
   logic        cpu_valid, cpu_wait, dma_ack, dma_valid, sd_we, sd_aux;
   logic [24:0] sd_addr;
   logic [7:0]  sd_din;

   sdram_slot_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clkref   (clkref),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_din  (cpu_din),
      .cpu_aux  (cpu_aux),
      .cpu_dout (cpu_dout),
      .cpu_valid(cpu_valid),
      .cpu_wait (cpu_wait),
      .dma_req  (dma_req),
      .dma_we   (dma_we),
      .dma_addr (dma_addr),
      .dma_din  (dma_din),
      .dma_aux  (dma_aux),
      .dma_ack  (dma_ack),
      .dma_dout (dma_dout),
      .dma_valid(dma_valid),
      .sd_addr  (sd_addr),
      .sd_we    (sd_we),
      .sd_din   (sd_din),
      .sd_aux   (sd_aux),
      .sd_dout  (sd_dout)
   );

   initial forever #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // 14-clk clkref, high for 7; held low when ref_run is clear.
   bit ref_run = 1'b0;
   int rc = 0;
   initial forever begin
      @(posedge clk);
      #1;
      if (ref_run) begin
         clkref = (rc < 7);
         rc     = (rc + 1) % SlotLen;
      end else begin
         clkref = 1'b0;
         rc     = 0;
      end
   end

   // Reference model: slot phase, owner (0 idle, 1 cpu, 2 dma) and expected outputs.
   int          m_ph = SlotLen - 1;
   bit          m_lk = 1'b0;
   bit          m_ref_d = 1'b1;
   int          m_own = 0;
   int          m_starve = 0;
   bit          m_rise, m_force;
   int          m_win;
   logic [24:0] e_addr = '0;
   logic        e_we = 1'b0, e_aux = 1'b0;
   logic [7:0]  e_din = '0;
   logic [15:0] e_cdout = '0, e_ddout = '0;
   logic        e_cv = 1'b0, e_dv = 1'b0, e_ack = 1'b0, e_wait = 1'b0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_ph = SlotLen - 1; m_lk = 1'b0; m_ref_d = 1'b1; m_own = 0; m_starve = 0;
         e_addr = '0; e_we = 1'b0; e_din = '0; e_aux = 1'b0;
         e_cdout = '0; e_ddout = '0;
         e_cv = 1'b0; e_dv = 1'b0; e_ack = 1'b0; e_wait = 1'b0;
      end else begin
         m_rise  = clkref && !m_ref_d;
         m_ref_d = clkref;
         e_cv = 1'b0; e_dv = 1'b0; e_ack = 1'b0;
         if (m_ph == DataPhase && m_own != 0 && !e_we) begin
            if (m_own == 1) begin e_cdout = sd_dout; e_cv = 1'b1; end
            else begin e_ddout = sd_dout; e_dv = 1'b1; end
         end
         if (m_lk && m_ph == SlotLen - 1) begin
            m_force = Guard && dma_req && (m_starve >= 8);
            m_win   = m_force ? 2 : (cpu_req ? 1 : (dma_req ? 2 : 0));
            if (m_win == 2 || !dma_req) m_starve = 0;
            else if (m_starve < 15) m_starve++;
            e_wait = m_force;
            m_own  = m_win;
            if (m_win == 1) begin
               e_addr = cpu_addr; e_we = cpu_we; e_din = cpu_din; e_aux = cpu_aux;
            end else if (m_win == 2) begin
               e_addr = dma_addr; e_we = dma_we; e_din = dma_din; e_aux = dma_aux;
               e_ack  = 1'b1;
            end else begin
               e_we = 1'b0;
            end
         end
         if (m_rise) begin m_ph = 0; m_lk = 1'b1; end
         else if (m_ph < SlotLen - 1) m_ph++;
      end
   end

   initial forever begin
      @(negedge clk);
      check("sd_addr", sd_addr, e_addr);
      check("sd_we", sd_we, e_we);
      check("sd_din", sd_din, e_din);
      check("sd_aux", sd_aux, e_aux);
      check("cpu_dout", cpu_dout, e_cdout);
      check("dma_dout", dma_dout, e_ddout);
      check("cpu_valid", cpu_valid, e_cv);
      check("dma_valid", dma_valid, e_dv);
      check("dma_ack", dma_ack, e_ack);
      check("cpu_wait", cpu_wait, e_wait);
   end

   task automatic wait_phase(input int p);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_ph != p && n < 200);
      total++;
      if (m_ph != p) begin
         bad++;
         $display("FAIL wait_phase: phase %0d want %0d", m_ph, p);
      end
   endtask

   int n_ack;

   initial begin
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Lock-up: clkref never rises, so nothing may be granted.
      cpu_req = 1'b1; dma_req = 1'b1; dma_we = 1'b1;
      cpu_addr = 25'h0001111; dma_addr = 25'h0002222;
      n_ack = 0;
      repeat (40) begin @(negedge clk); if (dma_ack) n_ack++; end
      check("lockup_ack_count", n_ack, 0);
      check("lockup_sd_we", sd_we, 1'b0);
      check("lockup_sd_addr", sd_addr, 25'h0);
      cpu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
      ref_run = 1'b1;

      // CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0001234; sd_dout = 16'hA55A;
      wait_phase(0);
      wait_phase(0);
      check("cpu_rd_addr", sd_addr, 25'h0001234);
      check("cpu_rd_we", sd_we, 1'b0);
      wait_phase(10);
      check("cpu_rd_valid", cpu_valid, 1'b1);
      check("cpu_rd_dout", cpu_dout, 16'hA55A);
      cpu_req = 1'b0;
      wait_phase(13);
      check("cpu_rd_addr_hold", sd_addr, 25'h0001234);

      // DMA write
      dma_req = 1'b1; dma_we = 1'b1; dma_din = 8'h3C; dma_aux = 1'b1; dma_addr = 25'h00ABCDE;
      wait_phase(0);
      check("dma_wr_ack", dma_ack, 1'b1);
      check("dma_wr_we", sd_we, 1'b1);
      check("dma_wr_din", sd_din, 8'h3C);
      check("dma_wr_aux", sd_aux, 1'b1);
      wait_phase(1);
      dma_req = 1'b0; dma_din = 8'h00;
      check("dma_wr_ack_once", dma_ack, 1'b0);
      wait_phase(13);
      check("dma_wr_din_hold", sd_din, 8'h3C);
      wait_phase(0);
      check("idle_we", sd_we, 1'b0);
      check("idle_addr_kept", sd_addr, 25'h00ABCDE);

      // DMA read at the top address
      dma_req = 1'b1; dma_we = 1'b0; dma_aux = 1'b0; dma_addr = 25'h1FFFFFF; sd_dout = 16'hC3E1;
      wait_phase(0);
      check("dma_rd_ack", dma_ack, 1'b1);
      check("dma_rd_addr", sd_addr, 25'h1FFFFFF);
      dma_req = 1'b0;
      wait_phase(10);
      check("dma_rd_valid", dma_valid, 1'b1);
      check("dma_rd_dout", dma_dout, 16'hC3E1);
      check("cpu_dout_held", cpu_dout, 16'hA55A);

      // Simultaneous requests: CPU first, DMA once CPU lets go
      cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 25'h0000100; dma_we = 1'b1; dma_din = 8'h77;
      sd_dout = 16'hBEEF;
      wait_phase(0);
      check("sim_no_ack", dma_ack, 1'b0);
      check("sim_cpu_addr", sd_addr, 25'h0000100);
      wait_phase(1);
      cpu_req = 1'b0;
      wait_phase(0);
      check("sim_dma_ack", dma_ack, 1'b1);
      check("sim_dma_din", sd_din, 8'h77);
      wait_phase(1);
      dma_req = 1'b0;

      // Both held for 18 slots
      cpu_req = 1'b1; dma_req = 1'b1;
      n_ack = 0;
      repeat (18 * SlotLen) begin @(negedge clk); if (dma_ack) n_ack++; end
      check("starve_ack_count", n_ack, Guard ? 2 : 0);
      cpu_req = 1'b0; dma_req = 1'b0;

      // clkref stops after lock: phase saturates and DMA is acked every clk
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 25'h0000042;
      ref_run = 1'b0;
      repeat (30) @(negedge clk);
      n_ack = 0;
      repeat (5) begin @(negedge clk); if (dma_ack) n_ack++; end
      check("sat_ack_count", n_ack, 5);
      check("sat_addr", sd_addr, 25'h0000042);
      dma_req = 1'b0; dma_we = 1'b0;
      ref_run = 1'b1;
      wait_phase(0);

      // Reset in the middle of a CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000555; sd_dout = 16'h5555;
      wait_phase(0);
      check("rst_pre_addr", sd_addr, 25'h0000555);
      wait_phase(5);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_valid", cpu_valid, 1'b0);
      check("rst_addr", sd_addr, 25'h0);
      check("rst_cpu_dout", cpu_dout, 16'h0);
      check("rst_dma_dout", dma_dout, 16'h0);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_no_grant", sd_addr, 25'h0);
      check("post_rst_no_data", cpu_dout, 16'h0);
      wait_phase(0);
      wait_phase(0);
      check("post_rst_grant", sd_addr, 25'h0000555);
      wait_phase(10);
      check("post_rst_valid", cpu_valid, 1'b1);
      check("post_rst_dout", cpu_dout, 16'h5555);
      cpu_req = 1'b0;
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
